// File: rtl/fmul_round_norm.sv
// FP32 multiply back end: normalize, round and pack the raw product into a 2-stage valid/ready pipeline.
// Build option FMUL_RNE_EN selects round-to-nearest-even; without it the significand is truncated.
module fmul_round_norm #(
  parameter int          BIAS = 127,
  parameter logic [31:0] QNAN = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [47:0] in_prod,
  input  logic [2:0]  in_spec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags
);
  localparam logic signed [9:0] EMAX = 10'(2 * BIAS + 1);

  logic               r_s1_valid;
  logic               r_s1_sign;
  logic signed [9:0]  r_s1_exp;
  logic [22:0]        r_s1_mant;
  logic               r_s1_g;
  logic               r_s1_s;
  logic [2:0]         r_s1_spec;

  logic               r_out_valid;
  logic [31:0]        r_out_result;
  logic [3:0]         r_out_flags;

  logic               w_adv1;
  logic               w_adv2;
  logic signed [9:0]  w_n_exp;
  logic [22:0]        w_n_mant;
  logic               w_n_g;
  logic               w_n_s;
  logic               w_up;
  logic [23:0]        w_sum;
  logic signed [9:0]  w_e;
  logic [22:0]        w_m;
  logic               w_inexact;
  logic [31:0]        w_result;
  logic [3:0]         w_flags;

  assign w_adv2   = !r_out_valid | out_ready;
  assign w_adv1   = !r_s1_valid | w_adv2;
  assign in_ready = w_adv1;

  // Product lies in [1,4): a set top bit means one extra position of shift.
  always_comb begin
    w_n_exp  = $signed(in_exp);
    w_n_mant = in_prod[45:23];
    w_n_g    = in_prod[22];
    w_n_s    = |in_prod[21:0];
    if (in_prod[47]) begin
      w_n_exp  = $signed(in_exp) + 10'sd1;
      w_n_mant = in_prod[46:24];
      w_n_g    = in_prod[23];
      w_n_s    = |in_prod[22:0];
    end
  end

`ifdef FMUL_RNE_EN
  assign w_up = r_s1_g & (r_s1_s | r_s1_mant[0]);
`else
  assign w_up = 1'b0;
`endif

  assign w_sum     = {1'b0, r_s1_mant} + {23'd0, w_up};
  assign w_e       = w_sum[23] ? (r_s1_exp + 10'sd1) : r_s1_exp;
  assign w_m       = w_sum[23] ? 23'd0 : w_sum[22:0];
  assign w_inexact = r_s1_g | r_s1_s;

  // Specials take priority over range checks; flags are {invalid, overflow, underflow, inexact}.
  always_comb begin
    w_result = {r_s1_sign, w_e[7:0], w_m};
    w_flags  = {3'b000, w_inexact};
    if (r_s1_spec[2] || (r_s1_spec[1] && r_s1_spec[0])) begin
      w_result = QNAN;
      w_flags  = {!r_s1_spec[2] || (r_s1_spec[1] && r_s1_spec[0]), 3'b000};
      if (r_s1_spec[2]) w_flags = {(r_s1_spec[1] && r_s1_spec[0]), 3'b000};
    end else if (r_s1_spec[1]) begin
      w_result = {r_s1_sign, 8'hFF, 23'd0};
      w_flags  = 4'b0000;
    end else if (r_s1_spec[0]) begin
      w_result = {r_s1_sign, 31'd0};
      w_flags  = 4'b0000;
    end else if (w_e >= EMAX) begin
      w_result = {r_s1_sign, 8'hFF, 23'd0};
      w_flags  = 4'b0101;
    end else if (w_e <= 10'sd0) begin
      w_result = {r_s1_sign, 31'd0};
      w_flags  = 4'b0011;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_result <= 32'd0;
      r_out_flags  <= 4'd0;
    end else begin
      if (w_adv1) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_sign <= in_sign;
          r_s1_exp  <= w_n_exp;
          r_s1_mant <= w_n_mant;
          r_s1_g    <= w_n_g;
          r_s1_s    <= w_n_s;
          r_s1_spec <= in_spec;
        end
      end
      // Output registers only change when the downstream slot is free, so a stalled result holds.
      if (w_adv2) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_result <= w_result;
          r_out_flags  <= w_flags;
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_flags  = r_out_flags;
endmodule

// File: tb/tb_fmul_round_norm.sv
// Self-checking bench for fmul_round_norm: directed plan cases, latency, back-pressure, reset, random stream.
module tb_fmul_round_norm;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_prod;
  logic [2:0]  in_spec;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  int n_tests = 0;
  int n_fail  = 0;

  fmul_round_norm dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_prod(in_prod), .in_spec(in_spec),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference: value-level rounding from the quotient/remainder of the product, returns {result, flags}.
  function automatic logic [35:0] model(input logic sign, input int exp_i,
                                        input logic [47:0] prod, input logic [2:0] spec);
    longint unsigned p, q, rem, half;
    int  sh, e;
    logic up, inexact;
    logic [31:0] res;
    logic [3:0]  fl;
    p    = 64'(prod);
    sh   = (p >= 64'h8000_0000_0000) ? 24 : 23;
    e    = exp_i + sh - 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    inexact = (rem != 0);
`ifdef FMUL_RNE_EN
    up = (rem > half) || ((rem == half) && (q % 2 == 1));
`else
    up = 1'b0;
`endif
    q = q + 64'(up);
    if (q == 64'h100_0000) begin
      q = 64'h80_0000;
      e = e + 1;
    end
    res = {sign, 8'(e), 23'(q)};
    fl  = {3'b000, inexact};
    if (spec[2] || (spec[1] && spec[0])) begin
      res = 32'h7FC0_0000;
      fl  = {(spec[1] && spec[0]), 3'b000};
    end else if (spec[1]) begin
      res = {sign, 8'hFF, 23'd0}; fl = 4'b0000;
    end else if (spec[0]) begin
      res = {sign, 31'd0}; fl = 4'b0000;
    end else if (e >= 255) begin
      res = {sign, 8'hFF, 23'd0}; fl = 4'b0101;
    end else if (e <= 0) begin
      res = {sign, 31'd0}; fl = 4'b0011;
    end
    return {res, fl};
  endfunction

  // One isolated transaction: checks accept, exact 2-cycle latency, and value against the model.
  task automatic single(input logic s, input int e, input logic [47:0] p, input logic [2:0] sp,
                        output logic [31:0] r, output logic [3:0] f);
    logic [35:0] exp_v;
    exp_v = model(s, e, p, sp);
    @(negedge clk);
    in_sign = s; in_exp = 10'(e); in_prod = p; in_spec = sp;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("single_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("latency_cycle1_invalid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("latency_cycle2_valid", 64'(out_valid), 64'd1);
    check("single_value", {28'd0, out_result, out_flags}, {28'd0, exp_v});
    r = out_result; f = out_flags;
  endtask

  function automatic logic [47:0] rand_prod();
    logic [47:0] p;
    p = {16'($urandom), $urandom};
    if (!p[47]) p[46] = 1'b1;
    if ($urandom_range(0, 3) == 0) p[21:0] = 22'd0;
    return p;
  endfunction

  logic [31:0] r_res;
  logic [3:0]  r_fl;
  logic [35:0] exp_q[$];
  logic [35:0] e_a, e_b, e_c, head;
  logic        have_item, hold_pending;
  logic [35:0] held;
  int          sent, cur_e;
  logic        cur_s;
  logic [47:0] cur_p;
  logic [2:0]  cur_sp;
  localparam int N_STREAM = 200;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_prod = '0; in_spec = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_result", 64'(out_result), 64'd0);
    check("reset_out_flags", 64'(out_flags), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    single(1'b0, 127, 48'h9000_0000_0000, 3'b000, r_res, r_fl);
    check("mul_1p5_sq", {r_res, r_fl}, {32'h4010_0000, 4'b0000});
    single(1'b0, 127, 48'h4000_0040_0000, 3'b000, r_res, r_fl);
    check("tie_even", {r_res, r_fl}, {32'h3F80_0000, 4'b0001});
    single(1'b0, 127, 48'h4000_00C0_0000, 3'b000, r_res, r_fl);
`ifdef FMUL_RNE_EN
    check("tie_odd", {r_res, r_fl}, {32'h3F80_0002, 4'b0001});
`else
    check("tie_odd", {r_res, r_fl}, {32'h3F80_0001, 4'b0001});
`endif
    single(1'b0, 127, 48'h7FFF_FFFF_FFFF, 3'b000, r_res, r_fl);
`ifdef FMUL_RNE_EN
    check("round_carry", {r_res, r_fl}, {32'h4000_0000, 4'b0001});
`else
    check("round_carry", {r_res, r_fl}, {32'h3FFF_FFFF, 4'b0001});
`endif
    single(1'b1, 254, 48'h8000_0000_0000, 3'b000, r_res, r_fl);
    check("overflow", {r_res, r_fl}, {32'hFF80_0000, 4'b0101});
    single(1'b0, 0, 48'h4000_0000_0000, 3'b000, r_res, r_fl);
    check("underflow", {r_res, r_fl}, {32'h0000_0000, 4'b0011});
    single(1'b0, 127, 48'h4000_0000_0000, 3'b011, r_res, r_fl);
    check("inf_times_zero", {r_res, r_fl}, {32'h7FC0_0000, 4'b1000});
    single(1'b1, 127, 48'h4000_0000_0000, 3'b100, r_res, r_fl);
    check("nan_in", {r_res, r_fl}, {32'h7FC0_0000, 4'b0000});
    single(1'b1, 127, 48'h4000_0000_0000, 3'b010, r_res, r_fl);
    check("inf_in", {r_res, r_fl}, {32'hFF80_0000, 4'b0000});
    single(1'b1, 300, 48'h4000_0000_0000, 3'b001, r_res, r_fl);
    check("zero_in", {r_res, r_fl}, {32'h8000_0000, 4'b0000});
    single(1'b0, 383, 48'hFFFF_FFFF_FFFF, 3'b000, r_res, r_fl);
    check("max_exp", {r_res, r_fl}, {32'h7F80_0000, 4'b0101});
    single(1'b0, -127, 48'h4000_0000_0000, 3'b000, r_res, r_fl);
    check("min_exp", {r_res, r_fl}, {32'h0000_0000, 4'b0011});

    // Back-pressure: stall output, offer three items.
    e_a = model(1'b0, 127, 48'h9000_0000_0000, 3'b000);
    e_b = model(1'b1, 130, 48'h4000_00C0_0000, 3'b000);
    e_c = model(1'b0, 100, 48'hC000_0000_0001, 3'b000);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    in_sign = 1'b0; in_exp = 10'd127; in_prod = 48'h9000_0000_0000; in_spec = 3'b000;
    #1 check("bp_accept_a", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_sign = 1'b1; in_exp = 10'd130; in_prod = 48'h4000_00C0_0000;
    #1 check("bp_accept_b", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_sign = 1'b0; in_exp = 10'd100; in_prod = 48'hC000_0000_0001;
    #1 check("bp_block_c", 64'(in_ready), 64'd0);
    check("bp_held_a", {28'd0, out_valid, out_result, out_flags}, {28'd0, 1'b1, e_a});
    repeat (3) begin
      @(negedge clk);
      #1 check("bp_stable_a", {28'd0, out_valid, out_result, out_flags}, {28'd0, 1'b1, e_a});
      check("bp_still_blocked", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", 64'(in_ready), 64'd1);
    check("bp_out_a", {28'd0, out_valid, out_result, out_flags}, {28'd0, 1'b1, e_a});
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("bp_out_b", {28'd0, out_valid, out_result, out_flags}, {28'd0, 1'b1, e_b});
    @(negedge clk);
    #1 check("bp_out_c", {28'd0, out_valid, out_result, out_flags}, {28'd0, 1'b1, e_c});
    @(negedge clk);
    #1 check("bp_drained", 64'(out_valid), 64'd0);

    // Reset with two items in flight.
    out_ready = 1'b0; in_valid = 1'b1; in_exp = 10'd127; in_prod = 48'h9000_0000_0000;
    @(negedge clk);
    in_exp = 10'd128;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_result", 64'(out_result), 64'd0);
    check("rst_mid_flags", 64'(out_flags), 64'd0);
    repeat (4) begin
      @(negedge clk);
      #1 check("rst_no_emit", 64'(out_valid), 64'd0);
    end

    // Random stream with random back-pressure against the model queue.
    sent = 0; have_item = 1'b0; hold_pending = 1'b0; held = '0;
    cur_s = 1'b0; cur_e = 0; cur_p = '0; cur_sp = '0;
    for (int cyc = 0; cyc < 4000 && (sent < N_STREAM || exp_q.size() > 0); cyc++) begin
      @(negedge clk);
      if (!have_item && sent < N_STREAM) begin
        cur_s  = 1'($urandom);
        cur_e  = int'($urandom_range(0, 397)) - 127;
        cur_p  = rand_prod();
        cur_sp = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
        have_item = 1'b1;
      end
      in_valid = have_item;
      in_sign = cur_s; in_exp = 10'(cur_e); in_prod = cur_p; in_spec = cur_sp;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (hold_pending) begin
        check("stream_hold_stable", {27'd0, out_valid, out_result, out_flags}, {27'd0, 1'b1, held});
        hold_pending = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_spurious", 64'(out_valid), 64'd0);
        end else begin
          head = exp_q.pop_front();
          check("stream_value", {28'd0, out_result, out_flags}, {28'd0, head});
        end
      end else if (out_valid) begin
        hold_pending = 1'b1;
        held = {out_result, out_flags};
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(cur_s, cur_e, cur_p, cur_sp));
        sent++;
        have_item = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("stream_all_sent", 64'(sent), 64'(N_STREAM));
    check("stream_all_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
